data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Parametrised data memory for the pipeline's MEM stage, the successor to the fixed 64-bit, 256-entry data memory. It is byte-addressed and supports RV64 load/store sizes (B/H/W/D) with byte-lane merge on stores and sign/zero extension on loads. A valid/ready request and response handshake lets the backing store insert programmable wait states. Misaligned and out-of-range accesses are detected and reported without side effects.

Parameters:
XLEN, 64, data/address width; fixed at 64 (RV64). The array is DEPTH x 64 bits.
DEPTH, 256, number of 64-bit doublewords; power of two, at least 2. ADDR_W = log2(DEPTH).
WAIT_CYCLES, 0, extra stall cycles between request acceptance and commit (0..15).
INIT_BASE, 256, simulation-start contents: mem[i] = i + INIT_BASE.

Ports:
clk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
req_unsigned  in  1  load zero-extends (LBU/LHU/LWU); ignored for stores and for size 3
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data, right-justified (low bytes used)
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  XLEN  load result; 0 for stores and errors
rsp_err  out  1  misaligned or out-of-range; valid only with rsp_valid

Behaviour:
- Reset (rst_n low, asynchronous): state goes to IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0 while rst_n is low. Memory contents are not affected by reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. If req_valid at a rising edge, the request is accepted and all request fields are latched. Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
  - WAIT: req_ready=0. A down-counter loaded with WAIT_CYCLES-1 counts down; at 0, next state is RESP.
  - RESP: req_ready=0, rsp_valid=1 for exactly one cycle. Next state is IDLE unconditionally.
- Commit: the memory write and read capture happen on the edge that enters RESP. rsp_rdata and rsp_err are registered on that same edge and held until the next commit or reset.
- Latency: for acceptance at edge E0, rsp_valid is high between edges E0+1+WAIT_CYCLES and E0+2+WAIT_CYCLES. Maximum throughput is one request per 2+WAIT_CYCLES cycles.
- Requests presented while req_ready=0 are ignored; the requester holds them.
- Address decode: offset = addr[2:0]; index = addr[ADDR_W+2:3].
  - Out of range when addr >= DEPTH*8, i.e. any set bit above ADDR_W+2.
  - Misaligned when offset is not a multiple of 2^size.
- Error response: no memory update; rsp_err=1, rsp_rdata=0. Out-of-range and misaligned are reported identically.
- Store: byte lanes offset..offset+2^size-1 of mem[index] are replaced by the low 2^size bytes of req_wdata; the other lanes are preserved. rsp_rdata=0.
- Load: the 2^size bytes at offset are extracted from mem[index]. They are sign-extended to 64 bits, or zero-extended when req_unsigned=1 and size<3.
- Reset mid-operation: if rst_n falls while in WAIT or before the commit edge, the latched request is discarded and no write occurs. A commit that has already happened is not undone.
- Back-to-back requests: a load issued after a store to the same address returns the stored data. Commit order equals acceptance order.

Test Plan:
1. Reset, then LD addr 0x10 (WAIT_CYCLES=0) -> req_ready drops the cycle after acceptance; rsp_valid one cycle later with rsp_rdata=0x102, rsp_err=0; req_ready=1 again the following cycle.
2. LB addr 0x11 -> 0x01. LHU addr 0x10 -> 0x0102. LW addr 0x14 -> 0x0.
3. SB wdata=0x80 to addr 0x18 -> LD 0x18 returns 0x180. LB 0x18 returns 0xFFFFFFFFFFFFFF80. LBU 0x18 returns 0x80.
4. SW wdata=0x12345678DEADBEEF to addr 0x20 -> LD 0x20 returns 0x00000000DEADBEEF. LW 0x20 returns 0xFFFFFFFFDEADBEEF. LWU 0x20 returns 0xDEADBEEF.
5. LW addr 0x12 (misaligned) and SD addr 0x800 (out of range, DEPTH=256) -> rsp_err=1, rsp_rdata=0. A following LD 0x0 returns 0x100, confirming no write occurred.
6. WAIT_CYCLES=3: accept SD 0x08 at E0 -> rsp_valid only between E0+4 and E0+5. Holding req_valid high during the busy window gives no extra acceptances. A repeat run with rst_n pulsed low at E0+2 -> no rsp_valid, and LD 0x08 later returns 0x101.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed RV64 data memory (B/H/W/D, sign/zero-extending loads),
// valid/ready request handshake, programmable wait states, misaligned/out-of-range errors.
module data_mem_ctrl #(
   parameter int XLEN        = 64,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 0,
   parameter int INIT_BASE   = 256
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err
);
   localparam int ADDR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_err_q, rsp_err_d;
   logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic              write_q, write_d;
   logic [1:0]        size_q, size_d;
   logic              unsigned_q, unsigned_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;

   logic              op_write, op_unsigned, op_oor, op_mis, op_err, sext;
   logic [1:0]        op_size;
   logic [XLEN-1:0]   op_addr, op_wdata;
   logic [2:0]        op_off;
   logic [5:0]        op_shamt;
   logic [ADDR_W-1:0] op_idx;
   logic [XLEN-1:0]   rd_word [DEPTH];
   logic [XLEN-1:0]   cur_word, shifted, size_mask, lane_mask, load_val, wr_data_d;
   logic              accept, commit, mem_we;

   // With zero wait states the commit edge is the accept edge, so the live request is used in IDLE.
   always_comb begin
      op_write    = (state_q == S_IDLE) ? req_write    : write_q;
      op_size     = (state_q == S_IDLE) ? req_size     : size_q;
      op_unsigned = (state_q == S_IDLE) ? req_unsigned : unsigned_q;
      op_addr     = (state_q == S_IDLE) ? req_addr     : addr_q;
      op_wdata    = (state_q == S_IDLE) ? req_wdata    : wdata_q;
      op_off      = op_addr[2:0];
      op_shamt    = {op_off, 3'b000};
      op_idx      = op_addr[ADDR_W+2:3];
      op_oor      = |op_addr[XLEN-1:ADDR_W+3];
      sext        = !op_unsigned;
      cur_word    = rd_word[op_idx];
      shifted     = cur_word >> op_shamt;
      case (op_size)
         2'd0: begin
            op_mis    = 1'b0;
            size_mask = {{(XLEN-8){1'b0}}, 8'hFF};
            load_val  = {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]};
         end
         2'd1: begin
            op_mis    = op_off[0];
            size_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
            load_val  = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
         end
         2'd2: begin
            op_mis    = |op_off[1:0];
            size_mask = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
            load_val  = {{(XLEN-32){sext & shifted[31]}}, shifted[31:0]};
         end
         default: begin
            op_mis    = |op_off;
            size_mask = '1;
            load_val  = shifted;
         end
      endcase
      op_err    = op_oor | op_mis;
      lane_mask = size_mask << op_shamt;
      wr_data_d = (cur_word & ~lane_mask) | ((op_wdata << op_shamt) & lane_mask);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_ready_d = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      write_d     = write_q;
      size_d      = size_q;
      unsigned_d  = unsigned_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      commit      = 1'b0;
      accept      = req_valid && req_ready_q;
      case (state_q)
         S_IDLE: begin
            req_ready_d = 1'b1;
            if (accept) begin
               req_ready_d = 1'b0;
               write_d     = req_write;
               size_d      = req_size;
               unsigned_d  = req_unsigned;
               addr_d      = req_addr;
               wdata_d     = req_wdata;
               if (WAIT_CYCLES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES - 1);
               end else begin
                  state_d = S_RESP;
                  commit  = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
            req_ready_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (commit) begin
         rsp_err_d   = op_err;
         rsp_rdata_d = (op_write || op_err) ? '0 : load_val;
      end
      mem_we = commit && op_write && !op_err;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         write_q     <= 1'b0;
         size_q      <= '0;
         unsigned_q  <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         write_q     <= write_d;
         size_q      <= size_d;
         unsigned_q  <= unsigned_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
      end
   end

   // Storage is never reset; each doubleword starts at its index plus INIT_BASE.
   for (genvar g = 0; g < DEPTH; g++) begin : g_mem
      logic [XLEN-1:0] word_q = XLEN'(INIT_BASE + g);
      always_ff @(posedge clk) begin
         if (mem_we && op_idx == ADDR_W'(g)) word_q <= wr_data_d;
      end
      assign rd_word[g] = word_q;
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: zero-wait and three-wait instances, scoreboard of expected
// responses checked when rsp_valid is seen.
module tb_data_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst_n0, rst_n3, req_valid0, req_valid3;
   logic        req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [63:0] req_addr, req_wdata;
   logic        req_ready0, req_ready3, rsp_valid0, rsp_valid3, rsp_err0, rsp_err3;
   logic [63:0] rsp_rdata0, rsp_rdata3;

   logic [64:0] q0[$], q3[$];
   string       t0[$], t3[$];
   int          vectors = 0, miscompares = 0, rsp3_pulses = 0;

   always #5 clk = ~clk;

   data_mem_ctrl #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n0), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid0),
      .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0));

   data_mem_ctrl #(.WAIT_CYCLES(3)) dut3 (
      .clk(clk), .rst_n(rst_n3), .req_valid(req_valid3), .req_ready(req_ready3),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid3),
      .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic take(input bit d3);
      logic [64:0] e;
      string       tag, who;
      int          sz;
      if (d3) begin sz = q3.size(); who = "rsp3"; end
      else begin sz = q0.size(); who = "rsp0"; end
      check({who, "_expected"}, 64'(sz != 0), 64'd1);
      if (sz != 0) begin
         if (d3) begin
            e = q3.pop_front(); tag = t3.pop_front();
            check({tag, "_data"}, rsp_rdata3, e[63:0]);
            check({tag, "_err"}, 64'(rsp_err3), 64'(e[64]));
         end else begin
            e = q0.pop_front(); tag = t0.pop_front();
            check({tag, "_data"}, rsp_rdata0, e[63:0]);
            check({tag, "_err"}, 64'(rsp_err0), 64'(e[64]));
         end
      end
   endtask

   always @(negedge clk) begin
      if (rsp_valid0) take(1'b0);
      if (rsp_valid3) begin
         rsp3_pulses++;
         take(1'b1);
      end
   end

   task automatic issue(input bit d3, input string tag, input logic w, input logic [1:0] s,
                        input logic u, input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] ed, input logic ee);
      int n;
      @(negedge clk);
      n = 0;
      while (!(d3 ? req_ready3 : req_ready0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready_timeout"}, 64'(n < 40), 64'd1);
      req_write = w; req_size = s; req_unsigned = u; req_addr = a; req_wdata = wd;
      if (d3) begin q3.push_back({ee, ed}); t3.push_back(tag); req_valid3 = 1'b1; end
      else begin q0.push_back({ee, ed}); t0.push_back(tag); req_valid0 = 1'b1; end
      @(negedge clk);
      req_valid0 = 1'b0;
      req_valid3 = 1'b0;
      n = 0;
      while ((d3 ? q3.size() : q0.size()) != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_rsp_timeout"}, 64'(n < 40), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, p;
      rst_n0 = 1'b0; rst_n3 = 1'b0; req_valid0 = 1'b0; req_valid3 = 1'b0;
      req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_ready0", 64'(req_ready0), 64'd0);
      check("rst_valid0", 64'(rsp_valid0), 64'd0);
      check("rst_rdata0", rsp_rdata0, 64'd0);
      check("rst_err0", 64'(rsp_err0), 64'd0);
      check("rst_ready3", 64'(req_ready3), 64'd0);
      check("rst_valid3", 64'(rsp_valid3), 64'd0);
      rst_n0 = 1'b1; rst_n3 = 1'b1;

      // Handshake timing of a single zero-wait load
      @(negedge clk);
      check("t1_ready_idle", 64'(req_ready0), 64'd1);
      req_write = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'h10;
      q0.push_back({1'b0, 64'h102}); t0.push_back("t1_ld10");
      req_valid0 = 1'b1;
      @(negedge clk);
      req_valid0 = 1'b0;
      check("t1_ready_drop", 64'(req_ready0), 64'd0);
      check("t1_valid_early", 64'(rsp_valid0), 64'd0);
      @(negedge clk);
      check("t1_valid", 64'(rsp_valid0), 64'd1);
      check("t1_ready_back", 64'(req_ready0), 64'd1);
      @(negedge clk);
      check("t1_valid_once", 64'(rsp_valid0), 64'd0);

      issue(0, "t2_lb11",   0, 2'd0, 0, 64'h11,  '0, 64'h01, 0);
      issue(0, "t2_lhu10",  0, 2'd1, 1, 64'h10,  '0, 64'h0102, 0);
      issue(0, "t2_lw14",   0, 2'd2, 0, 64'h14,  '0, 64'h0, 0);
      issue(0, "t2_ld7f8",  0, 2'd3, 0, 64'h7F8, '0, 64'h1FF, 0);
      issue(0, "t2_lbu7f9", 0, 2'd0, 1, 64'h7F9, '0, 64'h01, 0);

      issue(0, "t3_sb18",  1, 2'd0, 0, 64'h18, 64'h80, 64'h0, 0);
      issue(0, "t3_ld18",  0, 2'd3, 0, 64'h18, '0, 64'h180, 0);
      issue(0, "t3_lb18",  0, 2'd0, 0, 64'h18, '0, 64'hFFFF_FFFF_FFFF_FF80, 0);
      issue(0, "t3_lbu18", 0, 2'd0, 1, 64'h18, '0, 64'h80, 0);

      issue(0, "t4_sw20",  1, 2'd2, 0, 64'h20, 64'h1234_5678_DEAD_BEEF, 64'h0, 0);
      issue(0, "t4_ld20",  0, 2'd3, 0, 64'h20, '0, 64'h0000_0000_DEAD_BEEF, 0);
      issue(0, "t4_lw20",  0, 2'd2, 0, 64'h20, '0, 64'hFFFF_FFFF_DEAD_BEEF, 0);
      issue(0, "t4_lwu20", 0, 2'd2, 1, 64'h20, '0, 64'h0000_0000_DEAD_BEEF, 0);
      issue(0, "t4_sh2a",  1, 2'd1, 0, 64'h2A, 64'hFFFF_0000_1111_BEEF, 64'h0, 0);
      issue(0, "t4_ld28",  0, 2'd3, 0, 64'h28, '0, 64'h0000_0000_BEEF_0105, 0);
      issue(0, "t4_lh2a",  0, 2'd1, 0, 64'h2A, '0, 64'hFFFF_FFFF_FFFF_BEEF, 0);

      issue(0, "t5_lw12_mis",  0, 2'd2, 0, 64'h12,  '0, 64'h0, 1);
      issue(0, "t5_lh13_mis",  0, 2'd1, 0, 64'h13,  '0, 64'h0, 1);
      issue(0, "t5_sd800_oor", 1, 2'd3, 0, 64'h800, 64'hCAFE_F00D_CAFE_F00D, 64'h0, 1);
      issue(0, "t5_sd3_mis",   1, 2'd3, 0, 64'h3,   64'h5555_5555_5555_5555, 64'h0, 1);
      issue(0, "t5_ld_hibit",  0, 2'd3, 0, 64'h8000_0000_0000_0010, '0, 64'h0, 1);
      issue(0, "t5_ld0",       0, 2'd3, 0, 64'h0,   '0, 64'h100, 0);

      // Three wait states: reset pulse before the commit edge discards the store
      n = 0;
      while (!req_ready3 && n < 40) begin @(negedge clk); n++; end
      check("t6a_ready_timeout", 64'(n < 40), 64'd1);
      p = rsp3_pulses;
      req_write = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
      req_addr = 64'h08; req_wdata = 64'h0BAD_0BAD_0BAD_0BAD;
      req_valid3 = 1'b1;
      @(negedge clk);
      req_valid3 = 1'b0;
      @(negedge clk);
      rst_n3 = 1'b0;
      #1;
      check("t6a_rst_ready", 64'(req_ready3), 64'd0);
      check("t6a_rst_valid", 64'(rsp_valid3), 64'd0);
      @(negedge clk);
      rst_n3 = 1'b1;
      repeat (6) @(negedge clk);
      check("t6a_no_rsp", 64'(rsp3_pulses - p), 64'd0);
      issue(1, "t6a_ld08", 0, 2'd3, 0, 64'h08, '0, 64'h101, 0);

      // Three wait states: exact response window, request held high while busy
      n = 0;
      while (!req_ready3 && n < 40) begin @(negedge clk); n++; end
      check("t6b_ready_timeout", 64'(n < 40), 64'd1);
      p = rsp3_pulses;
      req_write = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
      req_addr = 64'h08; req_wdata = 64'hA5A5_5A5A_0123_4567;
      q3.push_back({1'b0, 64'h0}); t3.push_back("t6b_sd08");
      req_valid3 = 1'b1;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("t6b_valid_e%0d", k), 64'(rsp_valid3), 64'(k == 4));
         check($sformatf("t6b_ready_e%0d", k), 64'(req_ready3), 64'(k >= 4));
         if (k == 4) req_valid3 = 1'b0;
      end
      repeat (6) @(negedge clk);
      check("t6b_one_rsp", 64'(rsp3_pulses - p), 64'd1);
      issue(1, "t6b_ld08", 0, 2'd3, 0, 64'h08, '0, 64'hA5A5_5A5A_0123_4567, 0);
      issue(1, "t6b_lh0e", 0, 2'd1, 0, 64'h0E, '0, 64'hFFFF_FFFF_FFFF_A5A5, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
